instruction_encoder: RTL and testbench

Sequential encoder and program loader for the 8-bit CPU. It accepts symbolic instructions (mnemonic code plus operand) over a valid/ready stream, packs each one into the 8-bit instruction word that the instruction decoder consumes, and writes the words to consecutive program-memory addresses. It sits between the host/debug loader and program RAM. It also flags illegal mnemonics, out-of-range operands and program overflow.

---
 rtl/cpu8_isa_pkg.sv | 45 ++++
 rtl/instruction_encoder_if.sv | 25 ++
 rtl/instruction_pack.sv | 29 ++
 rtl/instruction_encoder.sv | 126 ++++++++++++
 tb/tb_instruction_encoder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu8_isa_pkg.sv
// Shared 8-bit CPU instruction-set definitions: mnemonic codes, word field
// positions and legality helpers used by both the encoder and the decoder.
package cpu8_isa_pkg;

    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 4;
    localparam int OPND_MSB = 3;
    localparam int OPND_LSB = 0;
    localparam int OPND_W   = OPND_MSB - OPND_LSB + 1;

    typedef enum logic [3:0] {
        OP_IN   = 4'h0,
        OP_OUT  = 4'h1,
        OP_LOAD = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_JNZ  = 4'hA,
        OP_JC   = 4'hB,
        OP_JNC  = 4'hC
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_DONE
    } enc_state_e;

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            OP_IN, OP_OUT, OP_LOAD, OP_ADD, OP_SUB, OP_AND,
            OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    // IN and OUT carry no operand; every other legal mnemonic does.
    function automatic logic has_operand(input logic [3:0] op);
        return is_legal_op(op) && (op != OP_IN) && (op != OP_OUT);
    endfunction

endpackage

// File: rtl/instruction_encoder_if.sv
// Symbolic-instruction input stream plus registered program-memory write port.
interface instruction_encoder_if #(
    parameter int ADDR_W = 4
) ();

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [7:0]        in_imm;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        output in_valid, in_op, in_imm, in_last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_imm, in_last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/instruction_pack.sv
// Combinational packer: mnemonic + operand -> 8-bit instruction word, with
// legality and operand-range classification.
module instruction_pack
    import cpu8_isa_pkg::*;
(
    input  logic [3:0] op_i,
    input  logic [7:0] imm_i,
    output logic [7:0] word_o,
    output logic       legal_o,
    output logic       range_err_o,
    output logic       write_o
);

    logic operand;

    always_comb begin
        operand     = has_operand(op_i);
        legal_o     = is_legal_op(op_i);
        // Range is only meaningful for a legal mnemonic that carries an operand.
        range_err_o = legal_o && operand && (|imm_i[7:OPND_W]);
        word_o      = '0;
        word_o[OPC_MSB:OPC_LSB] = op_i;
        if (operand) begin
            word_o[OPND_MSB:OPND_LSB] = imm_i[OPND_W-1:0];
        end
        write_o     = legal_o && !range_err_o;
    end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: packs symbolic instructions and writes them to consecutive
// program-memory addresses, tracking count, session state and sticky errors.
module instruction_encoder
    import cpu8_isa_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    instruction_encoder_if.slave   bus,
    output logic [ADDR_W:0]        count,
    output logic                   busy,
    output logic                   done,
    output logic                   err_illegal,
    output logic                   err_range,
    output logic                   err_overflow
);

    localparam int              DEPTH_I = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];

    enc_state_e        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ill_q, ill_d;
    logic              rng_q, rng_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;

    logic [7:0]        pk_word;
    logic              pk_legal;
    logic              pk_range;
    logic              pk_write;

    instruction_pack u_pack (
        .op_i        (bus.in_op),
        .imm_i       (bus.in_imm),
        .word_o      (pk_word),
        .legal_o     (pk_legal),
        .range_err_o (pk_range),
        .write_o     (pk_write)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ill_d   = ill_q;
        rng_d   = rng_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        // start outranks any offered word, so nothing is accepted that cycle.
        if (start) begin
            state_d = ST_LOAD;
            count_d = '0;
            ill_d   = 1'b0;
            rng_d   = 1'b0;
            ovf_d   = 1'b0;
            addr_d  = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (bus.in_valid && (count_q != DEPTH)) begin
                        if (!pk_legal) ill_d = 1'b1;
                        if (pk_range)  rng_d = 1'b1;
                        if (pk_write) begin
                            we_d    = 1'b1;
                            addr_d  = count_q[ADDR_W-1:0];
                            wdata_d = pk_word;
                            count_d = count_q + 1'b1;
                        end
                        // A final word ends the session even when full or dropped.
                        if (bus.in_last) begin
                            state_d = ST_DONE;
                        end else if (count_d == DEPTH) begin
                            state_d = ST_FULL;
                        end
                    end
                end
                ST_FULL: begin
                    if (bus.in_valid) ovf_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            ill_q   <= 1'b0;
            rng_q   <= 1'b0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            ill_q   <= ill_d;
            rng_q   <= rng_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_LOAD) && (count_q != DEPTH);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign count        = count_q;
    assign busy         = (state_q == ST_LOAD);
    assign done         = (state_q == ST_DONE);
    assign err_illegal  = ill_q;
    assign err_range    = rng_q;
    assign err_overflow = ovf_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed scenarios plus randomized
// load sessions checked against a behavioural program-loader model.
module tb_instruction_encoder;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam int MS_IDLE = 0;
    localparam int MS_LOAD = 1;
    localparam int MS_FULL = 2;
    localparam int MS_DONE = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   count;
    logic              busy, done, err_illegal, err_range, err_overflow;

    instruction_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instruction_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .bus          (bus),
        .count        (count),
        .busy         (busy),
        .done         (done),
        .err_illegal  (err_illegal),
        .err_range    (err_range),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t exp_q[$];
    wr_t got;

    // Behavioural model of the loader session
    int m_state = MS_IDLE;
    int m_count = 0;
    int m_ill   = 0;
    int m_rng   = 0;
    int m_ovf   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: addr %0d data 0x%02h, none required",
                         int'(bus.mem_addr), int'(bus.mem_wdata));
            end else begin
                got = exp_q.pop_front();
                check("wr_addr", int'(bus.mem_addr), got.addr);
                check("wr_data", int'(bus.mem_wdata), got.data);
                check("wr_cycle", cyc, got.cyc);
            end
        end
    end

    function automatic int legal_op(input int op);
        return (op <= 5) || (op >= 8 && op <= 12);
    endfunction

    // Spec rules applied to one accepted instruction.
    task automatic model_accept(input int op, input int imm, input int last);
        wr_t w;
        if (!legal_op(op)) begin
            m_ill = 1;
        end else if (op > 1 && imm > 15) begin
            m_rng = 1;
        end else begin
            w.addr = m_count % DEPTH;
            w.data = op * 16 + ((op <= 1) ? 0 : imm);
            w.cyc  = cyc;
            exp_q.push_back(w);
            m_count++;
        end
        if (last) m_state = MS_DONE;
        else if (m_count == DEPTH) m_state = MS_FULL;
    endtask

    task automatic send(input int op, input int imm, input int last);
        int waited;
        waited = 0;
        bus.in_op    = 4'(op);
        bus.in_imm   = 8'(imm);
        bus.in_last  = last[0];
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            waited++;
            if (waited > 40) begin
                n_total++;
                $display("FAIL accept_timeout: in_ready %0d after %0d cycles, required 1", int'(bus.in_ready), waited);
                bus.in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        model_accept(op, imm, last);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Caller may leave in_valid high to exercise start priority.
    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        m_state = MS_LOAD;
        m_count = 0;
        m_ill   = 0;
        m_rng   = 0;
        m_ovf   = 0;
    endtask

    task automatic hold_valid(input int n);
        bus.in_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        if (m_state == MS_FULL) m_ovf = 1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"},    int'(count),        m_count);
        check({tag, "_busy"},     int'(busy),         int'(m_state == MS_LOAD));
        check({tag, "_done"},     int'(done),         int'(m_state == MS_DONE));
        check({tag, "_in_ready"}, int'(bus.in_ready), int'(m_state == MS_LOAD));
        check({tag, "_err_ill"},  int'(err_illegal),  m_ill);
        check({tag, "_err_rng"},  int'(err_range),    m_rng);
        check({tag, "_err_ovf"},  int'(err_overflow), m_ovf);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_we"},    int'(bus.mem_we),    0);
        check({tag, "_mem_addr"},  int'(bus.mem_addr),  0);
        check({tag, "_mem_wdata"}, int'(bus.mem_wdata), 0);
        check_status(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, op, imm;
        reset        = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_imm   = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset");
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check_all_zero("idle");

        // Basic encode
        do_start();
        send(3, 5, 0);
        send(10, 12, 1);
        check_status("basic");
        check("basic_count_is_2", int'(count), 2);
        check("basic_done", int'(done), 1);

        // IN/OUT operand forcing
        do_start();
        send(0, 255, 0);
        send(1, 200, 1);
        check_status("inout");
        check("inout_no_range", int'(err_range), 0);

        // Illegal and out-of-range drops
        do_start();
        send(7, 3, 0);
        send(2, 16, 0);
        send(2, 3, 1);
        check_status("drops");
        check("drops_count_is_1", int'(count), 1);

        // Overflow
        do_start();
        for (int i = 0; i < DEPTH; i++) send(3, i, 0);
        check_status("full");
        check("full_in_ready", int'(bus.in_ready), 0);
        hold_valid(4);
        check_status("overflow");
        check("overflow_flag", int'(err_overflow), 1);

        // Final word as the DEPTH-th write ends in DONE
        do_start();
        for (int i = 0; i < DEPTH; i++) send(4, i, int'(i == DEPTH - 1));
        check_status("last_at_full");

        // Restart with start and in_valid together
        do_start();
        send(6, 1, 0);
        send(3, 1, 0);
        send(3, 2, 0);
        bus.in_op    = 4'h3;
        bus.in_imm   = 8'h09;
        bus.in_valid = 1'b1;
        do_start();
        check_status("restart");
        send(4, 7, 1);
        check_status("restart_after");

        // Reset in the cycle after an accept
        do_start();
        send(3, 2, 0);
        reset        = 1'b1;
        bus.in_op    = 4'h3;
        bus.in_imm   = 8'h04;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        m_state = MS_IDLE;
        m_count = 0;
        m_ill   = 0;
        m_rng   = 0;
        m_ovf   = 0;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("midreset_hold");

        // Randomized sessions
        for (int s = 0; s < 24; s++) begin
            do_start();
            n = $urandom_range(1, DEPTH + 3);
            for (int i = 0; i < n; i++) begin
                if (m_state != MS_LOAD) break;
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                op = $urandom_range(0, 15);
                if (op <= 1)            imm = $urandom_range(0, 255);
                else if (legal_op(op))  imm = $urandom_range(0, 20);
                else                    imm = $urandom_range(0, 15);
                send(op, imm, int'(i == n - 1));
            end
            if (m_state == MS_FULL) hold_valid($urandom_range(1, 3));
            check_status("rand");
        end

        repeat (3) @(posedge clk);
        #1;
        check("pending_writes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
